// File: rtl/cnn_pkg.sv
// Shared CNN definitions: layer geometry, pooling FSM states and the element type.
package cnn_pkg;

  localparam int CONV_X    = 24;
  localparam int CONV_Y    = 24;
  localparam int CONV_SIZE = 69;
  localparam int POOL_X    = CONV_X / 2;
  localparam int POOL_Y    = CONV_Y / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POOL = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  typedef logic signed [CONV_SIZE-1:0] conv_elem_t;

endpackage

// File: rtl/max_pool_layer_if.sv
// Bundle between a conv_layer channel (master side) and a max_pool_layer (slave side).
interface max_pool_layer_if #(
  parameter int CONV_X = cnn_pkg::CONV_X,
  parameter int CONV_Y = cnn_pkg::CONV_Y,
  parameter int DATA_W = cnn_pkg::CONV_SIZE
);

  logic                     conv_done;
  logic signed [DATA_W-1:0] conv_result [CONV_X][CONV_Y];
  logic signed [DATA_W-1:0] pool_result [CONV_X/2][CONV_Y/2];
  logic                     pool_done;
  logic                     pool_busy;

  modport master (
    output conv_done,
    output conv_result,
    input  pool_result,
    input  pool_done,
    input  pool_busy
  );

  modport slave (
    input  conv_done,
    input  conv_result,
    output pool_result,
    output pool_done,
    output pool_busy
  );

endinterface

// File: rtl/max4_signed.sv
// Combinational signed maximum of four values, with optional clamp of negative results to zero.
module max4_signed #(
  parameter int DATA_W = 69,
  parameter int RELU   = 1
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic signed [DATA_W-1:0] i_c,
  input  logic signed [DATA_W-1:0] i_d,
  output logic signed [DATA_W-1:0] o_max
);

  logic signed [DATA_W-1:0] w_ab;
  logic signed [DATA_W-1:0] w_cd;
  logic signed [DATA_W-1:0] w_m;

  assign w_ab = (i_a > i_b) ? i_a : i_b;
  assign w_cd = (i_c > i_d) ? i_c : i_d;
  assign w_m  = (w_ab > w_cd) ? w_ab : w_cd;

  generate
    if (RELU != 0) begin : g_relu
      assign o_max = w_m[DATA_W-1] ? '0 : w_m;
    end else begin : g_pass
      assign o_max = w_m;
    end
  endgenerate

endmodule

// File: rtl/max_pool_layer.sv
// 2x2 max-pool over one conv channel: one window per clock, row-major, after conv_done rises.
module max_pool_layer
  import cnn_pkg::*;
#(
  parameter int CONV_X = cnn_pkg::CONV_X,
  parameter int CONV_Y = cnn_pkg::CONV_Y,
  parameter int DATA_W = cnn_pkg::CONV_SIZE,
  parameter int RELU   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  max_pool_layer_if.slave       bus
);

  localparam int N_ROW = CONV_X / 2;
  localparam int N_COL = CONV_Y / 2;
  localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;

  pool_state_t              r_state;
  pool_state_t              w_state_next;
  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic                     r_done;
  logic                     r_busy;
  logic signed [DATA_W-1:0] r_pool [N_ROW][N_COL];

  logic                     w_wr_en;
  logic                     w_last_row;
  logic                     w_last_col;
  logic [ROW_W:0]           w_x0;
  logic [ROW_W:0]           w_x1;
  logic [COL_W:0]           w_y0;
  logic [COL_W:0]           w_y1;
  logic signed [DATA_W-1:0] w_max;

  // Window origin is (2r, 2c); the odd neighbour just sets the low bit.
  assign w_x0 = {r_row, 1'b0};
  assign w_x1 = {r_row, 1'b1};
  assign w_y0 = {r_col, 1'b0};
  assign w_y1 = {r_col, 1'b1};

  assign w_last_row = (r_row == ROW_W'(N_ROW - 1));
  assign w_last_col = (r_col == COL_W'(N_COL - 1));

  max4_signed #(
    .DATA_W (DATA_W),
    .RELU   (RELU)
  ) u_max4 (
    .i_a   (bus.conv_result[w_x0][w_y0]),
    .i_b   (bus.conv_result[w_x0][w_y1]),
    .i_c   (bus.conv_result[w_x1][w_y0]),
    .i_d   (bus.conv_result[w_x1][w_y1]),
    .o_max (w_max)
  );

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.conv_done) w_state_next = POOL;
      end
      POOL: begin
        // Losing conv_done means the source map was cleared; drop the window.
        if (!bus.conv_done) begin
          w_state_next = IDLE;
        end else begin
          w_wr_en = 1'b1;
          if (w_last_row && w_last_col) w_state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.conv_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < N_ROW; i++) begin
        for (int j = 0; j < N_COL; j++) begin
          r_pool[i][j] <= '0;
        end
      end
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == POOL);
      r_done  <= (w_state_next == DONE);
      if (r_state == IDLE) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_wr_en) begin
        r_pool[r_row][r_col] <= w_max;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign bus.pool_result = r_pool;
  assign bus.pool_done   = r_done;
  assign bus.pool_busy   = r_busy;

endmodule

// File: doc/max_pool_layer.md
Name: max_pool_layer

Overview:
- Consumer of one conv_layer output channel: waits for conv_done, then walks the CONV_X x CONV_Y result array and reduces each 2x2 window to its signed maximum.
- Optionally applies ReLU, producing a (CONV_X/2) x (CONV_Y/2) pooled map, one window per clock.
- Raises pool_done for the next stage.
- Eight instances sit after conv_layer, one per conv_result_n.

Parameters:
- CONV_X, 24, rows of input map (must be even).
- CONV_Y, 24, columns of input map (must be even).
- DATA_W, 69, signed width of input and output elements (matches conv_result width).
- RELU, 1, 1 = clamp negative results to 0; 0 = pure max-pool.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- conv_done  input  1  start/valid from conv_layer; conv_result is valid only while high.
- conv_result  input  signed [DATA_W-1:0] [CONV_X-1:0][CONV_Y-1:0]  conv map being read.
- pool_result  output reg  signed [DATA_W-1:0] [CONV_X/2-1:0][CONV_Y/2-1:0]  pooled map.
- pool_done  output reg  1  pooled map complete and stable.
- pool_busy  output reg  1  high while windows are being processed.

Behaviour:
- Reset (rst=1 at a posedge, priority over everything):
  - state=IDLE, r=c=0.
  - pool_done=0, pool_busy=0, all pool_result elements = 0.
  - A reset during POOL aborts the pass immediately.
- States: IDLE, POOL, DONE.
- IDLE:
  - conv_done=1 sampled -> POOL, pool_busy=1, r=c=0.
  - pool_result keeps its previous contents.
- POOL, each cycle:
  - m = signed max of conv_result[2r][2c], [2r][2c+1], [2r+1][2c], [2r+1][2c+1].
  - If RELU=1 and m<0, m=0.
  - pool_result[r][c] <= m.
  - Index advance is row-major: c increments; at c=CONV_Y/2-1, c wraps to 0 and r increments.
  - On the last window (r=CONV_X/2-1, c=CONV_Y/2-1): write it, set pool_done=1, pool_busy=0, go to DONE.
- Latency: the last write and pool_done rise occur (CONV_X/2)*(CONV_Y/2) edges after the start edge. Default is 144 edges.
- Abort: conv_done=0 sampled while in POOL (conv_layer has zeroed its outputs):
  - The current window is not written.
  - Go to IDLE with pool_busy=0, pool_done=0.
  - Already-written pool_result entries are kept; the map is not valid.
- DONE:
  - Hold pool_done=1 and pool_result stable while conv_done=1.
  - conv_done=0 sampled -> IDLE, pool_done=0; pool_result is retained.
  - A new pass starts only from IDLE, so conv_done must drop between passes.
- Comparison arithmetic: full DATA_W signed compare, no truncation or saturation. Output width equals input width.
- pool_busy and pool_done are never high together.

Decomposition:
- Shared package cnn_pkg holds:
  - CONV_X, CONV_Y, CONV_SIZE (69), POOL_X=CONV_X/2, POOL_Y=CONV_Y/2.
  - State enum typedef pool_state_t {IDLE, POOL, DONE}.
  - Element typedef conv_elem_t = logic signed [CONV_SIZE-1:0].
- One combinational sub-module, max4_signed: four DATA_W signed inputs plus RELU parameter -> one output. It is reused by later pooling stages.
- FSM, index counters and the output array stay in max_pool_layer.

Test Plan:
- Ramp, RELU=1: conv_result[x][y]=x*24+y, conv_done held high for 200 cycles -> after 144 edges pool_done=1; pool_result[r][c]=(2r+1)*24+2c+1, so [0][0]=25 and [11][11]=575; pool_busy low.
- All negative: every element=-5 except [1][1]=-2, conv_done high. RELU=1 -> all pool_result=0. RELU=0 -> [0][0]=-2, all others -5.
- Extreme widths: window holds 2^67-1, -2^68, 0, 7 -> output 2^67-1, with no overflow or sign flip.
- Abort: conv_done dropped at edge 50 of POOL -> pool_done stays 0, pool_busy falls, state IDLE. First 49 pooled entries (r=0..3 full, [4][0]) are written; a following full pass completes normally.
- Reset mid-pass: rst=1 at edge 100 -> next cycle all pool_result=0, pool_done=0, pool_busy=0. Releasing rst with conv_done=1 starts a fresh 144-edge pass.
- Handshake/retention: after DONE, lower conv_done, change conv_result to all 9 -> pool_result unchanged, pool_done=0. Raise conv_done -> new pass ends with all pool_result=9.
